stream_serializer: RTL
======================

STREAM_SERIALIZER -- requirements
Module: stream_serializer

Interface
REQ-001 Parameter DIV, default 4: clock cycles per output bit; legal range 1..256.
REQ-002 Parameter DEPTH, default 4: input FIFO depth in 64-bit words; power of two, at least 2.
REQ-003 D_CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 D_RST  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 D_OFF  input  1  pause; high freezes the bit serializer.
REQ-006 IN  input  64 [0:63]  stream word from mmu; bit IN[0] is transmitted first.
REQ-007 IN_VALID  input  1  IN holds a valid word.
REQ-008 IN_READY  output  1  block can accept a word this cycle.
REQ-009 BIT_OUT  output  1  current serial bit.
REQ-010 BIT_VALID  output  1  BIT_OUT is an active bit period.
REQ-011 LED_0  output  1  FIFO empty.
REQ-012 LED_1  output  1  FIFO full.
REQ-013 LED_2  output  1  serializer busy (state SHIFT).

Function
REQ-014 A word SHALL be accepted on a rising edge where IN_VALID and IN_READY are both high; IN is written to the FIFO tail.
REQ-015 IN_READY SHALL equal NOT full, combinational from registered count; a same-cycle pop SHALL NOT let a push enter a full FIFO.
REQ-016 The FIFO SHALL use wrap-around read/write pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits (0..DEPTH).
REQ-017 A push into a full FIFO SHALL be impossible; a pop from an empty FIFO SHALL be impossible; simultaneous push and pop SHALL leave the count unchanged.
REQ-018 The FSM SHALL have two states: IDLE and SHIFT.
REQ-019 IDLE: if the FIFO is non-empty and D_OFF is low, load the head word into a 64-bit shift register, pop it, clear the bit and divider counters, and go to SHIFT.
REQ-020 SHIFT: BIT_OUT = shift register bit 0, BIT_VALID = NOT D_OFF.
REQ-021 While D_OFF is low, the divider counter SHALL increment each cycle; at DIV-1 it SHALL wrap to 0, shift the register one position toward bit 0, and increment the bit counter.
REQ-022 At the divider wrap with the bit counter at 63: if the FIFO is non-empty, load the next word (back-to-back, no gap cycle); otherwise go to IDLE.
REQ-023 While D_OFF is high, the state, shift register and both counters SHALL hold, BIT_OUT SHALL hold, and the FIFO SHALL still accept words.
REQ-024 Latency: a word accepted at edge t into an empty FIFO with an IDLE FSM SHALL be loaded at edge t+1; bit 0 is valid from t+1 for DIV cycles.
REQ-025 Each word SHALL occupy exactly 64*DIV unpaused cycles of BIT_VALID.
REQ-026 In IDLE, BIT_OUT and BIT_VALID SHALL be 0.
REQ-027 LED_0, LED_1 and LED_2 SHALL be driven from registered state (count, FSM).

Reset
REQ-028 D_RST high at a rising edge SHALL clear the FIFO pointers and count, set FSM=IDLE, and clear the shift register and counters; this applies mid-word and discards buffered data.
REQ-029 Output values after reset: IN_READY=1, BIT_OUT=0, BIT_VALID=0, LED_0=1, LED_1=0, LED_2=0.
REQ-030 D_RST SHALL take priority over IN_VALID and D_OFF in the same cycle.

Structure
REQ-031 The shared package doppio_pkg SHALL hold: the WORD_W=64 constant, the stream word typedef logic [0:63], and the FSM state enum {IDLE, SHIFT}.
REQ-032 The FIFO SHALL be a separate sub-module named word_fifo, parameterized by DEPTH, exposing full, empty and count; the top module holds the FSM and serializer.

Verification
REQ-033 Reset: assert D_RST for 2 cycles -> IN_READY=1, LED_0=1, LED_1=0, LED_2=0, BIT_VALID=0.
REQ-034 Single word, DIV=4: IN=64'hA000_0000_0000_0001 -> BIT_OUT=1 for cycles 1-4, 0 for 5-8, 1 for 9-12, 0 until bit 63 = 1; FSM IDLE after 256 cycles; LED_0=1.
REQ-035 Fill: push 5 words with the FSM paused (D_OFF=1) -> 4 accepted, LED_1=1, IN_READY=0 on the 5th; release D_OFF -> 4 words back-to-back, 1024 contiguous BIT_VALID cycles.
REQ-036 Pause mid-word: D_OFF=1 for 10 cycles at bit 20 -> BIT_VALID=0 and BIT_OUT held; total word time 256+10 cycles; no bit is lost or duplicated.
REQ-037 Reset mid-word at bit 30 with 2 words queued -> next cycle IDLE, LED_0=1, no further BIT_VALID.
REQ-038 Simultaneous push and pop at count=2 -> count stays 2, data order preserved (compare 3 sequential words).

Source files
------------

// File: rtl/doppio_pkg.sv
// Shared types and constants for the 64-bit stream serializer slice.
package doppio_pkg;

    localparam int WORD_W = 64;

    typedef logic [0:WORD_W-1] word_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter width that stays at least one bit wide even when the range is 1.
    function automatic int unsigned width_of(input int unsigned range_v);
        return (range_v > 32'd1) ? $clog2(range_v) : 32'd1;
    endfunction

endpackage

// File: rtl/stream_serializer_if.sv
// Word-stream handshake between the mmu (master) and the serializer (slave).
interface stream_serializer_if;
    import doppio_pkg::*;

    word_t IN;
    logic  IN_VALID;
    logic  IN_READY;

    modport master (output IN, output IN_VALID, input IN_READY);
    modport slave  (input IN, input IN_VALID, output IN_READY);

endinterface

// File: rtl/stream_serializer_chk.sv
// Invariant checks on the serializer's observable outputs.
module stream_serializer_chk (
    input logic D_CLK,
    input logic D_RST,
    input logic D_OFF,
    input logic in_ready,
    input logic bit_out,
    input logic bit_valid,
    input logic led_0,
    input logic led_1,
    input logic led_2
);

    a_ready_is_not_full: assert property (@(posedge D_CLK) disable iff (D_RST)
        in_ready == ~led_1);

    a_empty_full_exclusive: assert property (@(posedge D_CLK) disable iff (D_RST)
        !(led_0 && led_1));

    a_idle_is_quiet: assert property (@(posedge D_CLK) disable iff (D_RST)
        !led_2 |-> (!bit_valid && !bit_out));

    a_pause_holds_bit: assert property (@(posedge D_CLK) disable iff (D_RST)
        (led_2 && D_OFF) |=> $stable(bit_out));

endmodule

// File: rtl/word_fifo.sv
// Word FIFO with wrap-around pointers and an explicit occupancy count.
module word_fifo
    import doppio_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           D_CLK,
    input  logic           D_RST,
    input  logic           push,
    input  word_t          din,
    input  logic           pop,
    output word_t          dout,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    word_t            mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Flags and guarded strobes; full/empty come from the registered count only.
    always_comb begin
        full_s    = (count_r == (PTR_W+1)'(DEPTH));
        empty_s   = (count_r == (PTR_W+1)'(0));
        push_ok_s = push & ~full_s;
        pop_ok_s  = pop & ~empty_s;
    end

    // Storage array; no reset needed, contents are qualified by the count.
    always_ff @(posedge D_CLK) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge D_CLK) begin
        if (D_RST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/stream_serializer.sv
// Buffers 64-bit words and shifts them out LSB-index-first, DIV clocks per bit.
module stream_serializer
    import doppio_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int DEPTH = 4
) (
    input  logic                D_CLK,
    input  logic                D_RST,
    input  logic                D_OFF,
    stream_serializer_if.slave  stream,
    output logic                BIT_OUT,
    output logic                BIT_VALID,
    output logic                LED_0,
    output logic                LED_1,
    output logic                LED_2
);

    localparam int DIV_W = width_of(DIV);
    localparam int PTR_W = $clog2(DEPTH);

    state_t           state_r;
    state_t           state_nx_s;
    word_t            shreg_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [5:0]       bit_cnt_r;

    word_t            fifo_head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [PTR_W:0]   fifo_count_s;

    logic             div_wrap_s;
    logic             load_s;
    logic             shift_s;
    logic             div_inc_s;

    word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .D_CLK (D_CLK),
        .D_RST (D_RST),
        .push  (stream.IN_VALID),
        .din   (stream.IN),
        .pop   (load_s),
        .dout  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign stream.IN_READY = ~fifo_full_s;
    assign div_wrap_s      = (div_cnt_r == DIV_W'(DIV - 1));

    // FSM state register.
    always_ff @(posedge D_CLK) begin
        if (D_RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state and datapath strobes; loading at bit 63 gives gap-free words.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        div_inc_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s && !D_OFF) begin
                    load_s     = 1'b1;
                    state_nx_s = SHIFT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (D_OFF) begin
                    state_nx_s = SHIFT;
                end else if (!div_wrap_s) begin
                    div_inc_s = 1'b1;
                end else if (bit_cnt_r != 6'd63) begin
                    shift_s = 1'b1;
                end else if (!fifo_empty_s) begin
                    load_s = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Shift register with divider and bit counters.
    always_ff @(posedge D_CLK) begin
        if (D_RST) begin
            shreg_r   <= '0;
            div_cnt_r <= '0;
            bit_cnt_r <= 6'd0;
        end else if (load_s) begin
            shreg_r   <= fifo_head_s;
            div_cnt_r <= '0;
            bit_cnt_r <= 6'd0;
        end else if (shift_s) begin
            shreg_r   <= {shreg_r[1:WORD_W-1], 1'b0};
            div_cnt_r <= '0;
            bit_cnt_r <= bit_cnt_r + 6'd1;
        end else if (div_inc_s) begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Outputs decoded from registered state; only BIT_VALID follows D_OFF directly.
    always_comb begin
        BIT_OUT   = (state_r == SHIFT) & shreg_r[0];
        BIT_VALID = (state_r == SHIFT) & ~D_OFF;
        LED_0     = (fifo_count_s == (PTR_W+1)'(0));
        LED_1     = (fifo_count_s == (PTR_W+1)'(DEPTH));
        LED_2     = (state_r == SHIFT);
    end

    stream_serializer_chk u_chk (
        .D_CLK     (D_CLK),
        .D_RST     (D_RST),
        .D_OFF     (D_OFF),
        .in_ready  (stream.IN_READY),
        .bit_out   (BIT_OUT),
        .bit_valid (BIT_VALID),
        .led_0     (LED_0),
        .led_1     (LED_1),
        .led_2     (LED_2)
    );

endmodule
